// File: rtl/ov7670_pkg.sv
// Shared types and default frame geometry for the OV7670 capture path.
// Geometry defaults are for RGB565 VGA: 640 px x 2 bytes per line, 480 lines per frame.
package ov7670_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      CAP  = 2'd2
   } ctrl_state_t;

   localparam int OV_H_BYTES = 1280;
   localparam int OV_V_LINES = 480;
endpackage

// File: rtl/ov7670_frame_monitor.sv
// Edge detect on vsync/href plus saturating byte/line counters; geometry strobes are
// combinational off registered counts (1-cycle edge latency); never stalls the camera.
module ov7670_frame_monitor
   import ov7670_pkg::*;
#(
   parameter int H_BYTES = OV_H_BYTES,
   parameter int V_LINES = OV_V_LINES
) (
   input  logic pclk,
   input  logic rst_n,
   input  logic i_vsync,
   input  logic i_href,
   output logic o_vs_rise,
   output logic o_line_err,
   output logic o_frame_geom_err
);
   localparam int BW = $clog2(H_BYTES + 1);
   localparam int LW = $clog2(V_LINES + 1);

   logic          r_vsync_d;
   logic          r_href_d;
   logic [BW-1:0] r_byte_cnt;
   logic [LW-1:0] r_line_cnt;
   logic          w_href_rise;
   logic          w_href_fall;

   assign o_vs_rise   = i_vsync & ~r_vsync_d;
   assign w_href_rise = i_href & ~r_href_d;
   assign w_href_fall = ~i_href & r_href_d;

   // Counts hold the pre-edge value on the cycle the edge is seen, so the checks
   // compare the completed line/frame before the counter clears.
   assign o_line_err       = w_href_fall & (r_byte_cnt != BW'(H_BYTES));
   assign o_frame_geom_err = o_vs_rise & (r_line_cnt != LW'(V_LINES));

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_d  <= 1'b0;
         r_href_d   <= 1'b0;
         r_byte_cnt <= '0;
         r_line_cnt <= '0;
      end else begin
         r_vsync_d <= i_vsync;
         r_href_d  <= i_href;
         if (i_href) begin
            if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 1'b1;
         end else if (w_href_fall) begin
            r_byte_cnt <= '0;
         end
         if (o_vs_rise) begin
            r_line_cnt <= '0;
         end else if (w_href_rise && (r_line_cnt != '1)) begin
            r_line_cnt <= r_line_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/ov7670_capture_ctrl.sv
// Frame sequencer: arm, skip settling frames, gate whole-frame fb1 writes, stop cleanly.
// Decisions land on the vsync-rise edge; start is dropped while busy, stop is deferred to a frame boundary.
module ov7670_capture_ctrl
   import ov7670_pkg::*;
#(
   parameter int H_BYTES     = OV_H_BYTES,
   parameter int V_LINES     = OV_V_LINES,
   parameter int SKIP_FRAMES = 2,
   parameter int FCNT_W      = 8
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic              href,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [FCNT_W-1:0] nframes,
   output logic              wr_block,
   output logic              busy,
   output logic              done,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              frame_err
);
   localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

   ctrl_state_t       r_state,     w_state_nx;
   logic [SW-1:0]     r_skip_cnt,  w_skip_cnt_nx;
   logic [FCNT_W-1:0] r_frame_cnt, w_frame_cnt_nx;
   logic [FCNT_W-1:0] r_nframes,   w_nframes_nx;
   logic              r_cont,      w_cont_nx;
   logic              r_stop_pend, w_stop_pend_nx;
   logic              r_wr_block,  w_wr_block_nx;
   logic              r_busy,      w_busy_nx;
   logic              r_done,      w_done_nx;
   logic              r_frame_err, w_frame_err_nx;

   logic              w_vs_rise;
   logic              w_line_err;
   logic              w_frame_geom_err;
   logic [FCNT_W-1:0] w_cnt_inc;
   logic [FCNT_W-1:0] w_target;

   ov7670_frame_monitor #(
      .H_BYTES (H_BYTES),
      .V_LINES (V_LINES)
   ) u_mon (
      .pclk             (pclk),
      .rst_n            (rst_n),
      .i_vsync          (vsync),
      .i_href           (href),
      .o_vs_rise        (w_vs_rise),
      .o_line_err       (w_line_err),
      .o_frame_geom_err (w_frame_geom_err)
   );

   assign w_cnt_inc = r_frame_cnt + 1'b1;
   assign w_target  = (r_nframes == '0) ? FCNT_W'(1) : r_nframes;

   always_comb begin
      w_state_nx     = r_state;
      w_skip_cnt_nx  = r_skip_cnt;
      w_frame_cnt_nx = r_frame_cnt;
      w_nframes_nx   = r_nframes;
      w_cont_nx      = r_cont;
      w_stop_pend_nx = r_stop_pend;
      w_wr_block_nx  = r_wr_block;
      w_busy_nx      = r_busy;
      w_done_nx      = 1'b0;
      w_frame_err_nx = r_frame_err;
      case (r_state)
         IDLE: begin
            w_wr_block_nx = 1'b1;
            if (start) begin
               w_state_nx     = ARM;
               w_busy_nx      = 1'b1;
               w_frame_err_nx = 1'b0;
               w_frame_cnt_nx = '0;
               w_skip_cnt_nx  = SW'(SKIP_FRAMES);
               w_cont_nx      = continuous;
               w_nframes_nx   = nframes;
            end
         end
         ARM: begin
            if (stop) begin
               w_state_nx     = IDLE;
               w_busy_nx      = 1'b0;
               w_done_nx      = 1'b1;
               w_stop_pend_nx = 1'b0;
            end else if (w_vs_rise) begin
               if (r_skip_cnt != '0) begin
                  w_skip_cnt_nx = r_skip_cnt - 1'b1;
               end else begin
                  w_state_nx    = CAP;
                  w_wr_block_nx = 1'b0;
               end
            end
         end
         CAP: begin
            if (w_line_err || w_frame_geom_err) w_frame_err_nx = 1'b1;
            if (stop) w_stop_pend_nx = 1'b1;
            if (w_vs_rise) begin
               w_frame_cnt_nx = w_cnt_inc;
               // A stop on the closing edge itself still ends the sequence here.
               if (r_stop_pend || stop || (!r_cont && (w_cnt_inc == w_target))) begin
                  w_state_nx     = IDLE;
                  w_wr_block_nx  = 1'b1;
                  w_busy_nx      = 1'b0;
                  w_done_nx      = 1'b1;
                  w_stop_pend_nx = 1'b0;
               end
            end
         end
         default: begin
            w_state_nx    = IDLE;
            w_wr_block_nx = 1'b1;
            w_busy_nx     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_skip_cnt  <= '0;
         r_frame_cnt <= '0;
         r_nframes   <= '0;
         r_cont      <= 1'b0;
         r_stop_pend <= 1'b0;
         r_wr_block  <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_skip_cnt  <= w_skip_cnt_nx;
         r_frame_cnt <= w_frame_cnt_nx;
         r_nframes   <= w_nframes_nx;
         r_cont      <= w_cont_nx;
         r_stop_pend <= w_stop_pend_nx;
         r_wr_block  <= w_wr_block_nx;
         r_busy      <= w_busy_nx;
         r_done      <= w_done_nx;
         r_frame_err <= w_frame_err_nx;
      end
   end

   assign wr_block  = r_wr_block;
   assign busy      = r_busy;
   assign done      = r_done;
   assign frame_cnt = r_frame_cnt;
   assign frame_err = r_frame_err;
endmodule
